// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM,
// single-entry holding register with valid/ready, and sticky error flags.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_rx,
    input  logic       rx_ready,
    input  logic       clear_errors,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic          sync1, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_n;
    logic          valid_n, fe_n, ov_n;
    logic          stop_sample, set_fe, set_ov;

    // Two-flop synchronizer for the asynchronous line; idles high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= serial_rx;
            rx_s  <= sync1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_idx_n;
            shreg         <= shreg_n;
            rx_data       <= data_n;
            rx_valid      <= valid_n;
            framing_error <= fe_n;
            overrun       <= ov_n;
            busy          <= (state_n != IDLE);
        end
    end

    // Next-state, bit sampling, holding-register handshake and error flags.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        data_n      = rx_data;
        valid_n     = rx_valid;
        stop_sample = 1'b0;
        set_fe      = 1'b0;
        set_ov      = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shreg_n   = {rx_s, shreg[7:1]};
                    cnt_n     = '0;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n       = '0;
                    stop_sample = 1'b1;
                    state_n     = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // A consumer transfer frees the slot; a new byte loading in the
        // same cycle overrides the clear and keeps rx_valid high.
        if (rx_valid && rx_ready) begin
            valid_n = 1'b0;
        end
        if (stop_sample) begin
            if (rx_s) begin
                if (!rx_valid || rx_ready) begin
                    data_n  = shreg;
                    valid_n = 1'b1;
                end else begin
                    set_ov = 1'b1;
                end
            end else begin
                set_fe = 1'b1;
            end
        end

        fe_n = clear_errors ? 1'b0 : framing_error;
        ov_n = clear_errors ? 1'b0 : overrun;
        if (set_fe) fe_n = 1'b1;
        if (set_ov) ov_n = 1'b1;
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed self-checking bench for uart_rx_deserializer at 16 clocks per bit.
module tb_uart_rx_deserializer;

    localparam int unsigned CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       serial_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic       clear_errors = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun;
    logic       busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .serial_rx    (serial_rx),
        .rx_ready     (rx_ready),
        .clear_errors (clear_errors),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .framing_error(framing_error),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hold the line at one level for a full bit time, ending 1 ns past a posedge.
    task automatic drive_bit(input logic b);
        serial_rx = b;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        @(posedge clock);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        serial_rx = 1'b1;
    endtask

    // Bounded wait at negedges for rx_valid.
    task automatic wait_valid(input int max_cyc, output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc) begin
            @(negedge clock);
            cyc++;
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    int   lat;
    logic ok;
    logic saw_busy;

    initial begin
        // Reset
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_fe", framing_error, 0);
        check("rst_ov", overrun, 0);
        check("rst_busy", busy, 0);
        idle_cycles(4);

        // Single frame 0x42, latency from start edge
        fork
            send_byte(8'h42, 1'b1);
            begin
                @(posedge clock);
                #1;
                wait_valid(300, lat, ok);
            end
        join
        check("f42_timeout", ok, 1);
        check("f42_latency_ok", (lat >= 150 && lat <= 156), 1);
        check("f42_data", rx_data, 8'h42);
        check("f42_fe", framing_error, 0);
        check("f42_ov", overrun, 0);
        idle_cycles(30);
        check("f42_busy_idle", busy, 0);
        check("f42_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        check("f42_valid_clr", rx_valid, 0);

        // Back-to-back 0x42 then 0x0D with one-cycle ready pulses
        fork
            begin
                send_byte(8'h42, 1'b1);
                drive_bit(1'b1);
                send_byte(8'h0D, 1'b1);
            end
            begin
                wait_valid(400, lat, ok);
                check("b2b0_timeout", ok, 1);
                check("b2b0_data", rx_data, 8'h42);
                rx_ready = 1'b1;
                @(negedge clock);
                rx_ready = 1'b0;
                check("b2b0_valid_clr", rx_valid, 0);
                wait_valid(400, lat, ok);
                check("b2b1_timeout", ok, 1);
                check("b2b1_data", rx_data, 8'h0D);
                rx_ready = 1'b1;
                @(negedge clock);
                rx_ready = 1'b0;
                check("b2b1_valid_clr", rx_valid, 0);
            end
        join
        idle_cycles(20);
        check("b2b_fe", framing_error, 0);
        check("b2b_ov", overrun, 0);

        // Start-bit glitch of 3 cycles
        @(posedge clock);
        #1 serial_rx = 1'b0;
        repeat (3) @(posedge clock);
        #1 serial_rx = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (busy) saw_busy = 1'b1;
        end
        check("glitch_busy_seen", saw_busy, 1);
        check("glitch_busy_end", busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_fe", framing_error, 0);
        check("glitch_ov", overrun, 0);

        // Framing error on 0xA5, then clear
        send_byte(8'hA5, 1'b0);
        idle_cycles(40);
        check("fe_flag", framing_error, 1);
        check("fe_valid", rx_valid, 0);
        check("fe_ov", overrun, 0);
        clear_errors = 1'b1;
        @(negedge clock);
        clear_errors = 1'b0;
        check("fe_cleared", framing_error, 0);

        // Overrun: 0x11 then 0x22 with no consumer
        send_byte(8'h11, 1'b1);
        drive_bit(1'b1);
        send_byte(8'h22, 1'b1);
        idle_cycles(30);
        check("ov_data", rx_data, 8'h11);
        check("ov_valid", rx_valid, 1);
        check("ov_flag", overrun, 1);
        check("ov_fe", framing_error, 0);
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        check("ov_valid_clr", rx_valid, 0);
        check("ov_sticky", overrun, 1);

        // Fill the holding register again, then reset during bit 3 of a frame
        send_byte(8'h33, 1'b1);
        idle_cycles(30);
        check("pre_rst_data", rx_data, 8'h33);
        @(posedge clock);
        #1 serial_rx = 1'b0;
        repeat (CPB * 4 + CPB / 2) @(posedge clock);
        @(negedge clock);
        check("mid_busy", busy, 1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mrst_data", rx_data, 8'h00);
        check("mrst_valid", rx_valid, 0);
        check("mrst_fe", framing_error, 0);
        check("mrst_ov", overrun, 0);
        check("mrst_busy", busy, 0);
        @(posedge clock);
        #1 begin
            reset = 1'b1;
            serial_rx = 1'b1;
        end
        idle_cycles(CPB * 2);
        check("post_rst_busy", busy, 0);

        // Clean frame after reset
        send_byte(8'h7E, 1'b1);
        wait_valid(100, lat, ok);
        check("f7e_timeout", ok, 1);
        check("f7e_data", rx_data, 8'h7E);
        check("f7e_fe", framing_error, 0);
        check("f7e_ov", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
